shift_add_mul8_ctrl: RTL and testbench



---
 rtl/shift_add_mul8_ctrl.sv | 176 +++++++++++++++++
 tb/tb_shift_add_mul8_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul8_ctrl.sv
// shift_add_mul8_ctrl: sequential 8x8 unsigned shift-and-add multiplier.
// A single 8-bit ripple adder is shared across eight RUN steps, one step per clock.
// Optional feature macro: MUL_ZERO_SKIP_EN. When it is defined, a zero operand
// finishes immediately with P=0.

// Shared 8-bit ripple-carry adder with a 9-bit sum.
module rippleadd (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [8:0] S
);

  logic [8:0] c;

  // Carry chain, evaluated LSB to MSB.
  always_comb begin
    c = 9'd0;
    S = 9'd0;
    for (int i = 0; i < 8; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    S[8] = c[8];
  end

endmodule

module shift_add_mul8_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] P
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  mcand;
  logic [7:0]  hi;
  logic [7:0]  lo;
  logic [3:0]  cnt;
  logic [15:0] p;
  logic        busy;
  logic        done;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [8:0]  sum;

`ifdef MUL_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (A == 8'h00) || (B == 8'h00);
`endif

  rippleadd u_add (
    .A(add_a),
    .B(add_b),
    .S(sum)
  );

  // Adder operand mux: the adder sees zeros outside RUN.
  always_comb begin
    add_a = 8'h00;
    add_b = 8'h00;
    if (state == RUN) begin
      add_a = hi;
      if (lo[0]) begin
        add_b = mcand;
      end else begin
        add_b = 8'h00;
      end
    end else begin
      add_a = 8'h00;
      add_b = 8'h00;
    end
  end

  // Next-state decode for the IDLE -> RUN -> FIN -> IDLE sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (START) begin
`ifdef MUL_ZERO_SKIP_EN
          if (zero_op) begin
            next_state = FIN;
          end else begin
            next_state = RUN;
          end
`else
          next_state = RUN;
`endif
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (cnt == 4'd7) begin
          next_state = FIN;
        end else begin
          next_state = RUN;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register, and BUSY/DONE flags registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == FIN);
    end
  end

  // Datapath: operand capture on accept, one shift-add step per RUN cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mcand <= 8'h00;
      hi    <= 8'h00;
      lo    <= 8'h00;
      cnt   <= 4'd0;
      p     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            mcand <= A;
            hi    <= 8'h00;
            lo    <= B;
            cnt   <= 4'd0;
`ifdef MUL_ZERO_SKIP_EN
            if (zero_op) begin
              p <= 16'h0000;
            end
`endif
          end
        end
        RUN: begin
          // The carry, sum[8], lands in hi[7]; the LSB shifts into lo.
          hi  <= sum[8:1];
          lo  <= {sum[0], lo[7:1]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            p <= {sum[8:1], sum[0], lo[7:1]};
          end
        end
        FIN: begin
          cnt <= cnt;
        end
        default: begin
          cnt <= 4'd0;
        end
      endcase
    end
  end

  assign BUSY = busy;
  assign DONE = done;
  assign P    = p;

endmodule

// File: tb/tb_shift_add_mul8_ctrl.sv
// Self-checking bench for shift_add_mul8_ctrl. The reference model is the plain
// product a*b. Expected timing: START is driven just after edge k and the
// result appears after edge k+9, or after edge k+1 for a zero-skip operation.
module tb_shift_add_mul8_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        BUSY;
  logic        DONE;
  logic [15:0] P;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 9;
`endif

  shift_add_mul8_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .P(P)
  );

  always #5 CLK = ~CLK;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request and wait (bounded) for DONE.
  // lat counts the edges from the request to the first DONE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [15:0] prod, output int busy_cnt);
    A = a; B = b; START = 1'b1;
    tick();
    START = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    lat = 1;
    busy_cnt = (BUSY === 1'b1) ? 1 : 0;
    while (DONE !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (BUSY === 1'b1) busy_cnt++;
    end
    prod = P;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; A = 8'h00; B = 8'h00;
    tick(); tick();
    RST = 1'b0;
    n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", BUSY); end
    n_tests++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", DONE); end
    n_tests++; if (P !== 16'h0000) begin n_fail++; $display("FAIL reset_p got %h want 0000", P); end
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [15:0] prod;
    do_op(8'hAD, 8'h39, lat, prod, bc);
    n_tests++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency got %0d want 9", lat); end
    n_tests++; if (prod !== 16'h2685) begin n_fail++; $display("FAIL basic_p got %h want 2685", prod); end
    n_tests++; if (bc != lat) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, lat); end
    tick();
    n_tests++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %0b want 0", DONE); end
    n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_busy_low got %0b want 0", BUSY); end
    tick(); tick(); tick();
    n_tests++; if (P !== 16'h2685) begin n_fail++; $display("FAIL basic_p_held got %h want 2685", P); end
  endtask

  task automatic test_corners();
    logic [7:0] ta [4] = '{8'hFF, 8'h01, 8'h80, 8'h00};
    logic [7:0] tb [4] = '{8'hFF, 8'h80, 8'h02, 8'hC8};
    logic [15:0] te [4] = '{16'hFE01, 16'h0080, 16'h0100, 16'h0000};
    int lat, bc, want_lat;
    logic [15:0] prod;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], lat, prod, bc);
      want_lat = (ta[i] == 8'h00 || tb[i] == 8'h00) ? ZERO_LAT : 9;
      n_tests++; if (prod !== te[i]) begin n_fail++; $display("FAIL corner_p[%0d] got %h want %h", i, prod, te[i]); end
      n_tests++; if (lat != want_lat) begin n_fail++; $display("FAIL corner_lat[%0d] got %0d want %0d", i, lat, want_lat); end
      tick();
      n_tests++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_fail++; $display("FAIL corner_idle[%0d] got busy=%0b done=%0b want 0/0", i, BUSY, DONE); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic [15:0] prod, want;
    int lat, bc, want_lat;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i == 3) a = 8'h00;
      if (i == 7) b = 8'h00;
      want = 16'(a) * 16'(b);
      want_lat = (a == 8'h00 || b == 8'h00) ? ZERO_LAT : 9;
      do_op(a, b, lat, prod, bc);
      n_tests++; if (prod !== want || lat != want_lat) begin
        n_fail++; $display("FAIL random[%0d] %h*%h got p=%h lat=%0d want p=%h lat=%0d", i, a, b, prod, lat, want, want_lat);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    logic [15:0] last_p = 16'hXXXX;
    A = 8'd3; B = 8'd5; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    A = 8'd9; B = 8'd9; START = 1'b1;
    tick();
    START = 1'b0;
    for (int t = 0; t < 25; t++) begin
      if (DONE === 1'b1) begin dones++; last_p = P; end
      tick();
    end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL ignored_done_count got %0d want 1", dones); end
    n_tests++; if (last_p !== 16'h000F) begin n_fail++; $display("FAIL ignored_p got %h want 000f", last_p); end
    n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL ignored_busy got %0b want 0", BUSY); end
  endtask

  task automatic test_back_to_back();
    int done_t [$];
    logic [15:0] done_p [$];
    A = 8'd2; B = 8'd3; START = 1'b1;
    for (int t = 1; t <= 29; t++) begin
      tick();
      if (t == 13) A = 8'd4;
      if (DONE === 1'b1) begin done_t.push_back(t); done_p.push_back(P); end
    end
    START = 1'b0;
    tick(); tick();
    n_tests++; if (done_t.size() != 3) begin
      n_fail++; $display("FAIL b2b_count got %0d want 3", done_t.size());
    end else begin
      n_tests++; if (done_t[0] != 9 || done_t[1] != 19 || done_t[2] != 29) begin
        n_fail++; $display("FAIL b2b_timing got %0d,%0d,%0d want 9,19,29", done_t[0], done_t[1], done_t[2]);
      end
      n_tests++; if (done_p[0] !== 16'h0006 || done_p[1] !== 16'h0006 || done_p[2] !== 16'h000C) begin
        n_fail++; $display("FAIL b2b_p got %h,%h,%h want 0006,0006,000c", done_p[0], done_p[1], done_p[2]);
      end
    end
    n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %0b want 0", BUSY); end
  endtask

  task automatic test_reset_mid();
    int dones = 0, lat, bc;
    logic [15:0] prod;
    A = 8'd173; B = 8'd57; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_tests++; if (BUSY !== 1'b0 || DONE !== 1'b0 || P !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_state got busy=%0b done=%0b p=%h want 0/0/0000", BUSY, DONE, P);
    end
    for (int t = 0; t < 12; t++) begin
      if (DONE === 1'b1) dones++;
      tick();
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL midreset_no_done got %0d want 0", dones); end
    do_op(8'd173, 8'd57, lat, prod, bc);
    n_tests++; if (prod !== 16'h2685 || lat != 9) begin
      n_fail++; $display("FAIL midreset_fresh got p=%h lat=%0d want 2685/9", prod, lat);
    end
    tick();
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = 8'h00; B = 8'h00;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
